sw_control_v3: RTL and testbench

// - Smith-Waterman local-alignment scorer for 2-bit DNA sequences. Loads a query and a reference serially,

---
 rtl/sw_control_v3_if.sv | 12 +
 rtl/sw_control_v3.sv | 191 +++++++++++++++++++
 tb/tb_sw_control_v3.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sw_control_v3_if.sv
// Beat/result bundle between the serial sequence loader, the SW scorer and the result collector.
interface sw_control_v3_if #(
  parameter int SW = 16
);
  logic [1:0]    Read_en;
  logic [1:0]    data_readin;
  logic          valid;
  logic [SW-1:0] max_result;

  modport master (output Read_en, data_readin, input valid, max_result);
  modport slave  (input Read_en, data_readin, output valid, max_result);
endinterface

// File: rtl/sw_control_v3.sv
// Smith-Waterman local-alignment scorer: serial 2-bit query/reference load, one DP cell per clock.
// Optional SW_SATURATE_EN: H saturates at all-ones instead of wrapping at SW bits.
module sw_control_v3 #(
  parameter int QMAX     = 64,
  parameter int RMAX     = 64,
  parameter int MATCH    = 2,
  parameter int MISMATCH = -1,
  parameter int GAP      = -1,
  parameter int SW       = 16
) (
  input  logic            clk,
  input  logic            rst,
  sw_control_v3_if.slave  bus
);

  localparam int QW  = $clog2(QMAX + 1);
  localparam int RW  = $clog2(RMAX + 1);
  localparam int QIW = $clog2(QMAX);
  localparam int RIW = $clog2(RMAX);
  localparam int XW  = SW + 2;

  localparam logic signed [XW-1:0] MATCH_X    = XW'(MATCH);
  localparam logic signed [XW-1:0] MISMATCH_X = XW'(MISMATCH);
  localparam logic signed [XW-1:0] GAP_X      = XW'(GAP);

  typedef enum logic [2:0] {IDLE, LOAD, CALC, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] qlen_q, qlen_d, j_q, j_d, qbase;
  logic [RW-1:0] rlen_q, rlen_d, i_q, i_d, rbase;
  logic [1:0]    query_q [0:QMAX-1];
  logic [1:0]    query_d [0:QMAX-1];
  logic [1:0]    ref_q   [0:RMAX-1];
  logic [1:0]    ref_d   [0:RMAX-1];
  logic [SW-1:0] row_q   [1:QMAX];
  logic [SW-1:0] row_d   [1:QMAX];
  logic [SW-1:0] diag_q, diag_d, left_q, left_d;
  logic [SW-1:0] hcell_q, hcell_d, max_q, max_d;
  logic          cell_vld_q, cell_vld_d;

  logic [QIW-1:0]         qidx;
  logic [RIW-1:0]         ridx;
  logic signed [XW-1:0]   s_cell, c_diag, c_up, c_left, c_best;
  logic [SW-1:0]          h_new;

  function automatic logic signed [XW-1:0] ext(input logic [SW-1:0] v);
    return $signed({2'b00, v});
  endfunction

  // Local alignment floors every cell at zero; the top end wraps or saturates.
  function automatic logic [SW-1:0] clamp_h(input logic signed [XW-1:0] v);
    if (v < 0) return '0;
`ifdef SW_SATURATE_EN
    else if (v > ext({SW{1'b1}})) return {SW{1'b1}};
`endif
    else return v[SW-1:0];
  endfunction

  // Cell (i,j): diag_q = H(i-1,j-1), row_q[j] = H(i-1,j), left_q = H(i,j-1).
  always_comb begin
    qidx   = QIW'(j_q - QW'(1));
    ridx   = RIW'(i_q - RW'(1));
    s_cell = (ref_q[ridx] == query_q[qidx]) ? MATCH_X : MISMATCH_X;
    c_diag = ext(diag_q) + s_cell;
    c_up   = ext(row_q[j_q]) + GAP_X;
    c_left = ext(left_q) + GAP_X;
    c_best = c_diag;
    if (c_up > c_best)   c_best = c_up;
    if (c_left > c_best) c_best = c_left;
    h_new  = clamp_h(c_best);
  end

  always_comb begin
    state_d    = state_q;
    qlen_d     = qlen_q;
    rlen_d     = rlen_q;
    i_d        = i_q;
    j_d        = j_q;
    query_d    = query_q;
    ref_d      = ref_q;
    row_d      = row_q;
    diag_d     = diag_q;
    left_d     = left_q;
    hcell_d    = hcell_q;
    cell_vld_d = 1'b0;
    max_d      = max_q;
    qbase      = qlen_q;
    rbase      = rlen_q;

    // Running max trails the cell datapath by one clock.
    if (cell_vld_q && (hcell_q > max_q)) max_d = hcell_q;

    case (state_q)
      IDLE, LOAD, DONE: begin
        case (bus.Read_en)
          2'b01, 2'b10: begin
            if (state_q == DONE) begin
              qbase  = '0;
              rbase  = '0;
              qlen_d = '0;
              rlen_d = '0;
              max_d  = '0;
            end
            state_d = LOAD;
            if (bus.Read_en == 2'b01) begin
              if (qbase < QW'(QMAX)) begin
                query_d[qbase[QIW-1:0]] = bus.data_readin;
                qlen_d = qbase + QW'(1);
              end
            end else begin
              if (rbase < RW'(RMAX)) begin
                ref_d[rbase[RIW-1:0]] = bus.data_readin;
                rlen_d = rbase + RW'(1);
              end
            end
          end
          2'b11: begin
            if (state_q != DONE) begin
              state_d = CALC;
              i_d     = RW'(1);
              j_d     = QW'(1);
              diag_d  = '0;
              left_d  = '0;
              max_d   = '0;
              row_d   = '{default: '0};
            end
          end
          default: ;
        endcase
      end
      CALC: begin
        if ((qlen_q == '0) || (rlen_q == '0)) begin
          state_d = DONE;
        end else begin
          row_d[j_q] = h_new;
          diag_d     = row_q[j_q];
          left_d     = h_new;
          hcell_d    = h_new;
          cell_vld_d = 1'b1;
          if (j_q == qlen_q) begin
            j_d    = QW'(1);
            diag_d = '0;
            left_d = '0;
            if (i_q == rlen_q) state_d = DRAIN;
            else               i_d = i_q + RW'(1);
          end else begin
            j_d = j_q + QW'(1);
          end
        end
      end
      DRAIN: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      qlen_q     <= '0;
      rlen_q     <= '0;
      i_q        <= '0;
      j_q        <= '0;
      query_q    <= '{default: '0};
      ref_q      <= '{default: '0};
      row_q      <= '{default: '0};
      diag_q     <= '0;
      left_q     <= '0;
      hcell_q    <= '0;
      cell_vld_q <= 1'b0;
      max_q      <= '0;
    end else begin
      state_q    <= state_d;
      qlen_q     <= qlen_d;
      rlen_q     <= rlen_d;
      i_q        <= i_d;
      j_q        <= j_d;
      query_q    <= query_d;
      ref_q      <= ref_d;
      row_q      <= row_d;
      diag_q     <= diag_d;
      left_q     <= left_d;
      hcell_q    <= hcell_d;
      cell_vld_q <= cell_vld_d;
      max_q      <= max_d;
    end
  end

  assign bus.valid      = (state_q == DONE);
  assign bus.max_result = max_q;

endmodule

// File: tb/tb_sw_control_v3.sv
// Directed bench for sw_control_v3: load sequences, start, check latency and max score.
module tb_sw_control_v3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  sw_control_v3_if #(.SW(16)) bus ();

  sw_control_v3 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // One beat: driven at the falling edge, sampled on the next rising edge, returns 1 time unit later.
  task automatic beat(input logic [1:0] re, input logic [1:0] d);
    @(negedge clk);
    bus.Read_en     = re;
    bus.data_readin = d;
    @(posedge clk);
    #1;
    bus.Read_en     = 2'b00;
  endtask

  task automatic load_seq(input logic [1:0] re, input logic [15:0] bases, input int n);
    logic [15:0] b;
    b = bases;
    for (int k = 0; k < n; k++) beat(re, b[2*k +: 2]);
  endtask

  // Start compute, count edges until valid, driving noise beats meanwhile.
  task automatic run(input string tag, input int exp_lat, input int exp_max, input logic [1:0] noise);
    int cnt;
    beat(2'b11, 2'b00);
    cnt = 0;
    check({tag, "_busy"}, int'(bus.valid), 0);
    while (!bus.valid && cnt < 6000) begin
      bus.Read_en = noise;
      @(posedge clk);
      #1;
      cnt++;
    end
    bus.Read_en = 2'b00;
    check({tag, "_lat"}, cnt, exp_lat);
    check({tag, "_valid"}, int'(bus.valid), 1);
    check({tag, "_max"}, int'(bus.max_result), exp_max);
  endtask

  initial begin
    bus.Read_en     = 2'b00;
    bus.data_readin = 2'b00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", int'(bus.valid), 0);
    check("reset_max", int'(bus.max_result), 0);
    rst = 1'b0;

    // ACGT vs ACGT with an X beat in the middle of loading
    load_seq(2'b01, 16'b11_10_01_00, 4);
    beat(2'bxx, 2'b11);
    load_seq(2'b10, 16'b11_10_01_00, 4);
    run("acgt", 17, 8, 2'b00);

    // 11 in DONE is ignored
    beat(2'b11, 2'b00);
    check("done_ign11_valid", int'(bus.valid), 1);
    check("done_ign11_max", int'(bus.max_result), 8);

    // First load beat out of DONE clears the result
    beat(2'b01, 2'b00);
    check("reload_valid", int'(bus.valid), 0);
    check("reload_max", int'(bus.max_result), 0);
    load_seq(2'b01, 16'b00_00_00, 3);
    load_seq(2'b10, 16'b11_11_11_11, 4);
    run("aaaa_tttt", 17, 0, 2'b00);

    // ACGTTG vs TTGA: TTG local match
    load_seq(2'b01, 16'b10_11_11_10_01_00, 6);
    load_seq(2'b10, 16'b00_10_11_11, 4);
    run("ttg", 25, 6, 2'b00);

    // Empty query
    beat(2'b10, 2'b00);
    run("empty_q", 1, 0, 2'b00);

    // 70 query beats, only 64 kept; 64 identical ref beats
    for (int k = 0; k < 70; k++) beat(2'b01, 2'(k % 4));
    for (int k = 0; k < 64; k++) beat(2'b10, 2'(k % 4));
    run("full", 4097, 128, 2'b00);

    // Reset mid-CALC
    beat(2'b01, 2'b00);
    load_seq(2'b01, 16'b11_10_01, 3);
    load_seq(2'b10, 16'b11_10_01_00, 4);
    beat(2'b11, 2'b00);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midcalc_rst_valid", int'(bus.valid), 0);
    check("midcalc_rst_max", int'(bus.max_result), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_idle", int'(bus.valid), 0);

    // Reload after reset, with query beats driven during CALC (ignored)
    load_seq(2'b01, 16'b11_10_01_00, 4);
    load_seq(2'b10, 16'b11_10_01_00, 4);
    run("after_rst", 17, 8, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
